// File: rtl/sr_flop_bank.sv
// Bank of WIDTH clocked SR flags with active-low S/R, an input synchroniser, a MODE policy for S=R=0, and sticky conflict reporting.
// Define SR_FLOP_BANK_EDGE_EN to act on falling edges of the synchronised S/R instead of levels.
module sr_flop_bank #(
  parameter int WIDTH       = 4,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [WIDTH-1:0] w_ss;
  logic [WIDTH-1:0] w_rs;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_conf;
  logic             w_any;
  logic [WIDTH-1:0] w_q_next;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qn;
  logic [WIDTH-1:0] r_conflict;
  logic [CNT_W-1:0] r_cnt;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_ss = S;
      assign w_rs = R;
    end else begin : g_sync
      logic [WIDTH-1:0] r_s_sync [SYNC_STAGES];
      logic [WIDTH-1:0] r_r_sync [SYNC_STAGES];

      // NOTE: the synchroniser is an array but still gets an explicit reset to 1, so stale lows are flushed by rst.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            r_s_sync[i] <= '1;
            r_r_sync[i] <= '1;
          end
        end else begin
          r_s_sync[0] <= S;
          r_r_sync[0] <= R;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_s_sync[i] <= r_s_sync[i-1];
            r_r_sync[i] <= r_r_sync[i-1];
          end
        end
      end

      assign w_ss = r_s_sync[SYNC_STAGES-1];
      assign w_rs = r_r_sync[SYNC_STAGES-1];
    end
  endgenerate

`ifdef SR_FLOP_BANK_EDGE_EN
  logic [WIDTH-1:0] r_ss_prev;
  logic [WIDTH-1:0] r_rs_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss_prev <= '1;
      r_rs_prev <= '1;
    end else begin
      r_ss_prev <= w_ss;
      r_rs_prev <= w_rs;
    end
  end

  assign w_set = r_ss_prev & ~w_ss;
  assign w_clr = r_rs_prev & ~w_rs;
`else
  assign w_set = ~w_ss;
  assign w_clr = ~w_rs;
`endif

  assign w_conf = w_set & w_clr;
  assign w_any  = |w_conf;

  // NOTE: default to the current state first so no path through this block leaves w_q_next unassigned (no latch).
  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_conf[i]) begin
        case (MODE)
          0:       w_q_next[i] = 1'b0;
          1:       w_q_next[i] = 1'b1;
          3:       w_q_next[i] = ~r_q[i];
          default: w_q_next[i] = r_q[i];
        endcase
      end else if (w_set[i]) begin
        w_q_next[i] = 1'b1;
      end else if (w_clr[i]) begin
        w_q_next[i] = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= '0;
      r_qn       <= '1;
      r_conflict <= '0;
      r_cnt      <= '0;
    end else begin
      r_q  <= w_q_next;
      r_qn <= ~w_q_next;
      if (clr_conflict) begin
        r_conflict <= w_conf;
        r_cnt      <= w_any ? CNT_W'(1) : '0;
      end else begin
        r_conflict <= r_conflict | w_conf;
        if (w_any && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign Q            = r_q;
  assign Qn           = r_qn;
  assign conflict     = r_conflict;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Bench for sr_flop_bank: six instances (all MODEs, a 2-bit counter, an unsynchronised one) on shared stimulus,
// compared against a history-based reference model plus directed expectations.
module tb_sr_flop_bank;

  localparam int NI = 6;
  localparam int P_MODE [NI] = '{0, 1, 2, 3, 0, 3};
  localparam int P_SYNC [NI] = '{2, 2, 2, 2, 2, 0};
  localparam int P_CNTW [NI] = '{8, 8, 8, 8, 2, 8};

  logic       clk;
  logic       rst;
  logic [3:0] s_in;
  logic [3:0] r_in;
  logic       clr_in;

  logic [3:0] q   [NI];
  logic [3:0] qn  [NI];
  logic [3:0] cf  [NI];
  logic [7:0] cnt [NI];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [3:0]           q_w;
    logic [3:0]           qn_w;
    logic [3:0]           cf_w;
    logic [P_CNTW[g]-1:0] cnt_w;

    sr_flop_bank #(
      .WIDTH(4), .MODE(P_MODE[g]), .SYNC_STAGES(P_SYNC[g]), .CNT_W(P_CNTW[g])
    ) u_dut (
      .clk(clk), .rst(rst), .S(s_in), .R(r_in), .clr_conflict(clr_in),
      .Q(q_w), .Qn(qn_w), .conflict(cf_w), .conflict_cnt(cnt_w)
    );

    assign q[g]   = q_w;
    assign qn[g]  = qn_w;
    assign cf[g]  = cf_w;
    assign cnt[g] = 8'(cnt_w);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every driven input is logged by edge number; the value an instance
  // sees at edge m is the input from SYNC edges earlier, or idle if a reset edge intervened.
  logic [3:0] s_log [0:4095];
  logic [3:0] r_log [0:4095];
  int         n_edge   = 0;
  int         last_rst = 0;
  logic [3:0] mq   [NI];
  logic [3:0] mcf  [NI];
  int         mcnt [NI];

  function automatic logic [3:0] hist(input bit is_s, input int k, input int m);
    if (m - k <= last_rst) return 4'hF;
    return is_s ? s_log[m-k] : r_log[m-k];
  endfunction

  task automatic model_edge();
    logic [3:0] ss, rs, ps, pr, ev_s, ev_r, cv;
    n_edge++;
    s_log[n_edge] = s_in;
    r_log[n_edge] = r_in;
    if (rst) begin
      last_rst = n_edge;
      for (int i = 0; i < NI; i++) begin
        mq[i] = 4'h0; mcf[i] = 4'h0; mcnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        ss = hist(1'b1, P_SYNC[i], n_edge);
        rs = hist(1'b0, P_SYNC[i], n_edge);
        ps = hist(1'b1, P_SYNC[i], n_edge - 1);
        pr = hist(1'b0, P_SYNC[i], n_edge - 1);
`ifdef SR_FLOP_BANK_EDGE_EN
        ev_s = ps & ~ss;
        ev_r = pr & ~rs;
`else
        ev_s = ~ss;
        ev_r = ~rs;
        ps = pr;
`endif
        for (int c = 0; c < 4; c++) begin
          if (ev_s[c] && ev_r[c]) begin
            if (P_MODE[i] == 0)      mq[i][c] = 1'b0;
            else if (P_MODE[i] == 1) mq[i][c] = 1'b1;
            else if (P_MODE[i] == 3) mq[i][c] = !mq[i][c];
          end else if (ev_s[c]) begin
            mq[i][c] = 1'b1;
          end else if (ev_r[c]) begin
            mq[i][c] = 1'b0;
          end
        end
        cv = ev_s & ev_r;
        if (clr_in) begin
          mcf[i]  = cv;
          mcnt[i] = (cv != 4'h0) ? 1 : 0;
        end else begin
          mcf[i] = mcf[i] | cv;
          if (cv != 4'h0 && mcnt[i] < (1 << P_CNTW[i]) - 1) mcnt[i]++;
        end
      end
    end
  endtask

  // Inputs change in the low phase; outputs are looked at on the following falling edge.
  task automatic drive(input logic [3:0] s, input logic [3:0] r, input logic c, input logic x);
    s_in = s; r_in = r; clr_in = c; rst = x;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int j = 0; j < 7; j++) begin
      drive(4'hF, 4'hF, 1'b0, j < 2);
      for (int g = 0; g < NI; g++) begin
        n_tests++;
        if (q[g] !== 4'h0 || qn[g] !== 4'hF || cf[g] !== 4'h0 || cnt[g] !== 8'd0) begin
          n_fail++;
          $display("FAIL reset dut%0d cyc%0d: q=%h qn=%h cf=%h cnt=%0d, expected q=0 qn=f cf=0 cnt=0",
                   g, j, q[g], qn[g], cf[g], cnt[g]);
        end
      end
    end
  endtask

  task automatic test_set_reset_latency();
    logic [3:0] e0 [6] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
    logic [3:0] e5 [6] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    for (int j = 0; j < 6; j++) begin
      drive(j < 3 ? 4'hE : 4'hF, j < 3 ? 4'hF : 4'hE, 1'b0, 1'b0);
      n_tests++;
      if (q[0] !== e0[j] || qn[0] !== ~e0[j]) begin
        n_fail++;
        $display("FAIL latency sync2 cyc%0d: q=%h qn=%h, expected q=%h qn=%h", j, q[0], qn[0], e0[j], ~e0[j]);
      end
      n_tests++;
      if (q[5] !== e5[j] || qn[5] !== ~e5[j]) begin
        n_fail++;
        $display("FAIL latency sync0 cyc%0d: q=%h qn=%h, expected q=%h qn=%h", j, q[5], qn[5], e5[j], ~e5[j]);
      end
    end
  endtask

  task automatic test_mode_sweep();
    logic [3:0] exp_q [4][5];
    exp_q[0] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    exp_q[1] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
    exp_q[2] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
    exp_q[3] = '{4'h1, 4'h1, 4'h0, 4'h1, 4'h0};
    drive(4'hE, 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b1, 1'b0);
    for (int j = 0; j < 5; j++) begin
      drive(j < 3 ? 4'hE : 4'hF, j < 3 ? 4'hE : 4'hF, 1'b0, 1'b0);
      for (int g = 0; g < 4; g++) begin
        n_tests++;
        if (q[g] !== exp_q[g][j] || qn[g] !== ~exp_q[g][j]) begin
          n_fail++;
          $display("FAIL mode%0d cyc%0d: q=%h qn=%h, expected q=%h", g, j, q[g], qn[g], exp_q[g][j]);
        end
      end
    end
    for (int g = 0; g < NI; g++) begin
      n_tests++;
      if (cf[g] !== 4'h1 || cnt[g] !== 8'd3) begin
        n_fail++;
        $display("FAIL mode_conflict dut%0d: cf=%h cnt=%0d, expected cf=1 cnt=3", g, cf[g], cnt[g]);
      end
    end
  endtask

  task automatic test_saturation_clear();
    int e4, e0;
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b1, 1'b0);
    for (int j = 0; j < 8; j++) begin
      drive(j < 6 ? 4'h0 : 4'hF, j < 6 ? 4'h0 : 4'hF, 1'b0, 1'b0);
      e0 = (j < 2) ? 0 : j - 1;
      e4 = (e0 > 3) ? 3 : e0;
      n_tests++;
      if (cnt[4] !== 8'(e4) || cnt[0] !== 8'(e0)) begin
        n_fail++;
        $display("FAIL saturate cyc%0d: cnt2b=%0d cnt8b=%0d, expected %0d and %0d", j, cnt[4], cnt[0], e4, e0);
      end
    end
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b1, 1'b0);
    for (int g = 0; g < NI; g++) begin
      n_tests++;
      if (cf[g] !== 4'h0 || cnt[g] !== 8'd0) begin
        n_fail++;
        $display("FAIL clear_idle dut%0d: cf=%h cnt=%0d, expected cf=0 cnt=0", g, cf[g], cnt[g]);
      end
    end
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b1, 1'b0);
    n_tests++;
    if (cf[0] !== 4'hF || cnt[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL clear_vs_conflict sync2: cf=%h cnt=%0d, expected cf=f cnt=1", cf[0], cnt[0]);
    end
    n_tests++;
    if (cf[5] !== 4'h0 || cnt[5] !== 8'd0) begin
      n_fail++;
      $display("FAIL clear_after_conflict sync0: cf=%h cnt=%0d, expected cf=0 cnt=0", cf[5], cnt[5]);
    end
  endtask

  task automatic test_mid_reset();
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    drive(4'h0, 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    n_tests++;
    if (q[0] !== 4'hF) begin
      n_fail++;
      $display("FAIL mid_reset_preset: q=%h, expected f", q[0]);
    end
    drive(4'h0, 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'hD, 1'b0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      for (int g = 0; g < NI; g++) begin
        n_tests++;
        if (q[g] !== 4'h0 || qn[g] !== 4'hF || cf[g] !== 4'h0 || cnt[g] !== 8'd0) begin
          n_fail++;
          $display("FAIL mid_reset dut%0d cyc%0d: q=%h qn=%h cf=%h cnt=%0d, expected q=0 qn=f cf=0 cnt=0",
                   g, j, q[g], qn[g], cf[g], cnt[g]);
        end
      end
      if (j < 3) drive(4'hF, 4'hF, 1'b0, 1'b0);
    end
  endtask

  task automatic test_edge_hold();
    logic exp_bit;
`ifdef SR_FLOP_BANK_EDGE_EN
    exp_bit = 1'b0;
`else
    exp_bit = 1'b1;
`endif
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) drive(4'hE, 4'hF, 1'b0, 1'b0);
    drive(4'hE, 4'hE, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) drive(4'hE, 4'hF, 1'b0, 1'b0);
    for (int g = 0; g < NI; g++) begin
      n_tests++;
      if (q[g][0] !== exp_bit || qn[g][0] !== ~exp_bit) begin
        n_fail++;
        $display("FAIL held_set_after_r_pulse dut%0d: q0=%b qn0=%b, expected q0=%b", g, q[g][0], qn[g][0], exp_bit);
      end
    end
    drive(4'hF, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] s, r;
    for (int j = 0; j < 400; j++) begin
      s = 4'($urandom | $urandom);
      r = 4'($urandom | $urandom);
      drive(s, r, $urandom_range(15) == 0, $urandom_range(63) == 0);
      for (int g = 0; g < NI; g++) begin
        n_tests++;
        if (q[g] !== mq[g] || qn[g] !== ~mq[g] || cf[g] !== mcf[g] || cnt[g] !== 8'(mcnt[g])) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: q=%h qn=%h cf=%h cnt=%0d, expected q=%h qn=%h cf=%h cnt=%0d",
                   g, j, q[g], qn[g], cf[g], cnt[g], mq[g], ~mq[g], mcf[g], mcnt[g]);
        end
      end
    end
  endtask

  initial begin
    s_in = 4'hF; r_in = 4'hF; clr_in = 1'b0; rst = 1'b1;
    test_reset();
    test_set_reset_latency();
`ifndef SR_FLOP_BANK_EDGE_EN
    test_mode_sweep();
    test_saturation_clear();
`endif
    test_mid_reset();
    test_edge_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
